// File: rtl/int_ctrl.sv
// Four-line priority interrupt controller with a 16-byte memory-mapped register window.
// Define INT_CTRL_SYNC_EN to insert a 2-flop synchronizer on each INT line.
module int_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  INT,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        int_req,
  output logic [1:0]  int_id,
  input  logic        int_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] OFF_PEND   = 2'd0;
  localparam logic [1:0] OFF_MASK   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_EOI    = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] int_id_nxt;
  logic [3:0] pend, pend_nxt;
  logic [3:0] mask, mask_nxt;
  logic [3:0] int_s;
  logic [3:0] int_prev;
  logic [3:0] edge_set;
  logic [3:0] ack_clr;
  logic [3:0] w1c;
  logic [3:0] masked;
  logic [1:0] arm_cnt;
  logic       armed;
  logic       in_window;
  logic       wr_pend, wr_mask, wr_eoi;
  logic [4:0] status;

`ifdef INT_CTRL_SYNC_EN
  localparam logic [1:0] ARM_LAST = 2'd3;
  logic [3:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= INT;
      sync2 <= sync1;
    end
  end

  assign int_s = sync2;
`else
  localparam logic [1:0] ARM_LAST = 2'd1;
  assign int_s = INT;
`endif

  // A line already high when reset releases must not look like a fresh edge,
  // so edge detection stays disarmed until the sample path has filled.
  assign armed = (arm_cnt == ARM_LAST);

  assign in_window = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_pend   = we && in_window && (addr[3:2] == OFF_PEND);
  assign wr_mask   = we && in_window && (addr[3:2] == OFF_MASK);
  assign wr_eoi    = we && in_window && (addr[3:2] == OFF_EOI);

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:4]};

  assign edge_set = armed ? (int_s & ~int_prev) : 4'b0000;
  assign ack_clr  = (state == REQ && int_ack) ? (4'b0001 << int_id) : 4'b0000;
  assign w1c      = wr_pend ? wdata[3:0] : 4'b0000;
  // Edge set is OR'ed in last so it beats a clear on the same bit.
  assign pend_nxt = (pend & ~(w1c | ack_clr)) | edge_set;
  assign mask_nxt = wr_mask ? wdata[3:0] : mask;
  assign masked   = pend & mask;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // NOTE: every state register takes the async reset; nothing here is a memory array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      int_id   <= 2'd0;
      pend     <= 4'b0000;
      mask     <= 4'b0000;
      int_prev <= 4'b0000;
      arm_cnt  <= 2'd0;
    end else begin
      state    <= state_nxt;
      int_id   <= int_id_nxt;
      pend     <= pend_nxt;
      mask     <= mask_nxt;
      int_prev <= int_s;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_nxt  = state;
    int_id_nxt = int_id;
    case (state)
      IDLE: begin
        if (|masked) begin
          state_nxt  = REQ;
          int_id_nxt = lowest_set(masked);
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nxt = SERVICE;
        end else if (!(pend_nxt[int_id] && mask_nxt[int_id])) begin
          state_nxt  = IDLE;
          int_id_nxt = 2'd0;
        end
      end
      SERVICE: begin
        if (wr_eoi) begin
          state_nxt  = IDLE;
          int_id_nxt = 2'd0;
        end
      end
      default: begin
        state_nxt  = IDLE;
        int_id_nxt = 2'd0;
      end
    endcase
  end

  assign int_req = (state == REQ);
  assign status  = {state, int_id, (state == SERVICE)};

  always_comb begin
    rdata = 32'd0;
    if (in_window) begin
      case (addr[3:2])
        OFF_PEND:   rdata = {28'd0, pend};
        OFF_MASK:   rdata = {28'd0, mask};
        OFF_STATUS: rdata = {27'd0, status};
        default:    rdata = 32'd0;
      endcase
    end
  end

endmodule
